// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: immediate-format select codes and the widths used
// by the immediate sign-extension unit.
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Width of the extended immediate produced by the datapath.
    localparam int DATA_WIDTH_DEFAULT = 32;

    // Immediate field taken from the instruction word: instr[31:7].
    localparam int IMD_IN_WIDTH = 25;

    // Immediate format select driven by the main decoder.
    typedef enum logic [1:0] {
        IMD_I = 2'b00,
        IMD_S = 2'b01,
        IMD_B = 2'b10,
        IMD_J = 2'b11
    } imd_src_e;

endpackage : cpu_pkg

// File: rtl/cpu_sign_extend_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cpu_sign_extend_unit
// Rebuilds and sign-extends the immediate of an RV32 instruction from
// instruction bits [31:7]. The extended value is available combinationally
// and as a copy registered on clk.
//
// Ports
//   clk        : clock for the registered copy
//   rst_n      : asynchronous active-low reset (clears imd_ext_q only)
//   imd        : instruction bits [31:7], imd[k] = instr[k+7]
//   imd_src    : immediate format select (I/S/B/J, see cpu_pkg::imd_src_e)
//   imd_ext    : combinational sign-extended immediate
//   imd_ext_q  : imd_ext registered on the rising edge of clk
// -----------------------------------------------------------------------------
module cpu_sign_extend_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [IMD_IN_WIDTH-1:0] imd,
    input  logic [1:0]              imd_src,
    output logic [DATA_WIDTH-1:0]   imd_ext,
    output logic [DATA_WIDTH-1:0]   imd_ext_q
);

    // The bit layouts below are RV32 specific; any other width is a build error.
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("cpu_sign_extend_unit: only DATA_WIDTH = 32 is supported");
    end

    // Format mux: scatter the instruction fields back into immediate order.
    // imd[24] (instr[31]) is the sign bit for every format. B and J offsets
    // are halfword aligned, so bit 0 is always zero. An unknown select drives
    // X so that a broken decoder is visible in simulation.
    always_comb begin
        imd_ext = {DATA_WIDTH{1'b0}};
        case (imd_src)
            IMD_I:   imd_ext = {{21{imd[24]}}, imd[23:13]};
            IMD_S:   imd_ext = {{21{imd[24]}}, imd[23:18], imd[4:0]};
            IMD_B:   imd_ext = {{20{imd[24]}}, imd[0], imd[23:18], imd[4:1], 1'b0};
            IMD_J:   imd_ext = {{12{imd[24]}}, imd[12:5], imd[13], imd[23:14], 1'b0};
            default: imd_ext = {DATA_WIDTH{1'bx}};
        endcase
    end

    // Registered copy: loads every cycle, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imd_ext_q <= {DATA_WIDTH{1'b0}};
        end else begin
            imd_ext_q <= imd_ext;
        end
    end

endmodule : cpu_sign_extend_unit

// File: tb/tb_cpu_sign_extend_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cpu_sign_extend_unit
// Scoreboard bench: the stimulus process pushes expected values into a queue
// and signals the monitor, which samples the DUT 1 time unit later and
// compares every queued entry against either imd_ext or imd_ext_q.
// -----------------------------------------------------------------------------
module tb_cpu_sign_extend_unit;

    logic        clk;
    logic        rst_n;
    logic [24:0] imd;
    logic [1:0]  imd_src;
    logic [31:0] imd_ext;
    logic [31:0] imd_ext_q;

    typedef struct {
        bit          use_q;
        logic [31:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb[$];
    event     chk_evt;
    int       n_tests = 0;
    int       n_fail  = 0;

    cpu_sign_extend_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imd       (imd),
        .imd_src   (imd_src),
        .imd_ext   (imd_ext),
        .imd_ext_q (imd_ext_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from the full instruction word using the
    // standard RV32 field positions.
    function automatic logic [31:0] ref_imm(input logic [24:0] f, input logic [1:0] sel);
        logic [31:0] ins;
        logic [31:0] r;
        ins = {f, 7'b0000000};
        case (sel)
            2'b00:   r = {{20{ins[31]}}, ins[31:20]};
            2'b01:   r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            2'b10:   r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            default: r = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        endcase
        return r;
    endfunction

    task automatic push_exp(input bit use_q, input logic [31:0] exp, input string name);
        sb_item_t it;
        it.use_q = use_q;
        it.exp   = exp;
        it.name  = name;
        sb.push_back(it);
    endtask

    // Apply a vector, queue its combinational expectation, leave 2 units for the check.
    task automatic apply_chk(input logic [24:0] f, input logic [1:0] sel,
                             input logic [31:0] exp, input string name);
        imd     = f;
        imd_src = sel;
        push_exp(1'b0, exp, name);
        -> chk_evt;
        #2;
    endtask

    // Monitor: one time unit after each stimulus event, drain and compare the queue.
    initial begin
        sb_item_t    it;
        logic [31:0] act;
        forever begin
            @(chk_evt);
            #1;
            while (sb.size() > 0) begin
                it  = sb.pop_front();
                act = it.use_q ? imd_ext_q : imd_ext;
                n_tests++;
                if (act !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [24:0] rf;
        logic [1:0]  rs;
        rst_n   = 1'b1;
        imd     = 25'h0000000;
        imd_src = 2'b00;

        // t=1: reset asserted between clock edges.
        #1;
        rst_n   = 1'b0;
        imd     = 25'h000A001;
        imd_src = 2'b00;
        push_exp(1'b0, 32'h00000005, "comb_during_reset");
        push_exp(1'b1, 32'h00000000, "q_async_reset");
        -> chk_evt;
        // t=7: release, register must hold 0 until the edge at t=15.
        #6;
        rst_n = 1'b1;
        #5;
        push_exp(1'b1, 32'h00000000, "q_before_first_edge");
        -> chk_evt;
        // t=16: after the edge at t=15.
        #4;
        push_exp(1'b1, 32'h00000005, "q_first_edge_addi");
        -> chk_evt;
        // t=18: new vector, registered at t=25.
        #2;
        apply_chk(25'h1000000, 2'b00, 32'hFFFFF800, "i_neg_min");
        #6;
        push_exp(1'b1, 32'hFFFFF800, "q_follows_comb");
        -> chk_evt;
        // t=28: reset mid-cycle clears the register without an edge.
        #2;
        rst_n = 1'b0;
        push_exp(1'b1, 32'h00000000, "q_midcycle_reset");
        -> chk_evt;
        #3;
        rst_n = 1'b1;
        #1;

        // Directed format vectors.
        apply_chk(25'h000A001, 2'b00, 32'h00000005, "i_addi_5");
        apply_chk(25'h0FFE000, 2'b00, 32'h000007FF, "i_max_pos");
        apply_chk(25'h000001F, 2'b01, 32'h0000001F, "s_low_field");
        apply_chk(25'h1000000, 2'b01, 32'hFFFFF800, "s_neg_min");
        apply_chk(25'h1FFFFFF, 2'b10, 32'hFFFFFFFE, "b_all_ones");
        apply_chk(25'h0000001, 2'b10, 32'h00000800, "b_bit11");
        apply_chk(25'h0000002, 2'b10, 32'h00000002, "b_bit1");
        apply_chk(25'h1FFFFFF, 2'b11, 32'hFFFFFFFE, "j_all_ones");
        apply_chk(25'h0000020, 2'b11, 32'h00001000, "j_bit12");
        apply_chk(25'h0002000, 2'b11, 32'h00000800, "j_bit11");
        apply_chk(25'h1000000, 2'b11, 32'hFFF00000, "j_neg_min");

        // Random vectors against the reference model.
        for (int i = 0; i < 1000; i++) begin
            rf = 25'($urandom);
            rs = 2'($urandom_range(3, 0));
            apply_chk(rf, rs, ref_imm(rf, rs), "random");
        end

        #5;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cpu_sign_extend_unit
